// File: rtl/activation_unit_pkg.sv
// Shared definitions for the activation stage: mode encodings, default widths
// and the zero-lane popcount used by the sparsity counter.
package activation_unit_pkg;

  // Activation mode, sampled alongside each input beat
  typedef enum logic [1:0] {
    ACT_BYP   = 2'd0,
    ACT_RELU  = 2'd1,
    ACT_LEAKY = 2'd2,
    ACT_CLIP  = 2'd3
  } act_mode_e;

  localparam int unsigned DEF_LANES      = 4;
  localparam int unsigned DEF_IN_W       = 21;
  localparam int unsigned DEF_OUT_W      = 16;
  localparam int unsigned DEF_LEAK_SHIFT = 3;
  localparam int unsigned DEF_CNT_W      = 32;

  // Widest lane count the zero popcount can handle
  localparam int unsigned MAX_LANES = 64;

  // Number of set flags; callers set one flag per zero-valued lane
  function automatic int unsigned count_set(input logic [MAX_LANES-1:0] flags);
    int unsigned n;
    n = 0;
    for (int i = 0; i < MAX_LANES; i++) begin
      n = n + {31'b0, flags[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/activation_unit_lane.sv
// One lane of the activation stage, purely combinational. The activation half
// feeds the S1 register; the saturation half narrows the S1 value for S2.
module act_lane import activation_unit_pkg::*; #(
  parameter int unsigned IN_W       = DEF_IN_W,
  parameter int unsigned OUT_W      = DEF_OUT_W,
  parameter int unsigned LEAK_SHIFT = DEF_LEAK_SHIFT
) (
  input  logic [IN_W-1:0]  x,
  input  logic [1:0]       mode,
  input  logic [OUT_W-1:0] clip_val,
  output logic [IN_W-1:0]  act_y,
  input  logic [IN_W-1:0]  sat_x,
  output logic [OUT_W-1:0] sat_y
);

  // Bits that must all agree with the sign for the value to fit in OUT_W
  localparam int unsigned HI_W = IN_W - OUT_W + 1;

  logic            neg;
  logic [IN_W-1:0] clip_ext;
  logic [IN_W-1:0] leak;
  logic [HI_W-1:0] hi;

  assign neg      = x[IN_W-1];
  // Clip ceiling is unsigned, so widen with zeros
  assign clip_ext = IN_W'(clip_val);
  // Arithmetic shift gives floor rounding for negative inputs
  assign leak     = IN_W'($signed(x) >>> LEAK_SHIFT);
  assign hi       = sat_x[IN_W-1:OUT_W-1];

  // Activation function selected by the beat's mode
  always_comb begin
    act_y = x;
    case (mode)
      ACT_BYP:   act_y = x;
      ACT_RELU:  act_y = neg ? '0 : x;
      ACT_LEAKY: act_y = neg ? leak : x;
      ACT_CLIP: begin
        // x is non-negative here, so an unsigned compare is correct
        if (neg)                 act_y = '0;
        else if (x > clip_ext)   act_y = clip_ext;
        else                     act_y = x;
      end
      default:   act_y = x;
    endcase
  end

  // Signed saturation to OUT_W, then truncation
  always_comb begin
    if (hi == '0 || hi == '1) begin
      sat_y = sat_x[OUT_W-1:0];
    end else if (sat_x[IN_W-1]) begin
      sat_y = {1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      sat_y = {1'b0, {(OUT_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/activation_unit.sv
// Multi-lane activation stage between the accumulator array and the next
// layer's input buffer. Two register stages: S1 holds activated lanes, S2
// holds saturated output lanes. Full valid/ready backpressure and a running
// count of zero-valued output lanes.
module activation_unit import activation_unit_pkg::*; #(
  parameter int unsigned LANES      = DEF_LANES,
  parameter int unsigned IN_W       = DEF_IN_W,
  parameter int unsigned OUT_W      = DEF_OUT_W,
  parameter int unsigned LEAK_SHIFT = DEF_LEAK_SHIFT,
  parameter int unsigned CNT_W      = DEF_CNT_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*IN_W-1:0]  in_data,
  input  logic [1:0]             mode,
  input  logic [OUT_W-1:0]       clip_val,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*OUT_W-1:0] out_data,
  output logic [CNT_W-1:0]       zero_cnt,
  input  logic                   cnt_clr
);

  logic                   s1_vld;
  logic [LANES*IN_W-1:0]  s1_data;
  logic [LANES*IN_W-1:0]  act_data;
  logic [LANES*OUT_W-1:0] sat_data;
  logic                   s2_adv;
  logic                   out_fire;
  logic [MAX_LANES-1:0]   zero_flags;
  logic [CNT_W-1:0]       zero_inc;

  assign s2_adv   = !out_valid || out_ready;
  assign in_ready = !s1_vld || s2_adv;
  assign out_fire = out_valid && out_ready;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    act_lane #(
      .IN_W       (IN_W),
      .OUT_W      (OUT_W),
      .LEAK_SHIFT (LEAK_SHIFT)
    ) u_lane (
      .x        (in_data[k*IN_W +: IN_W]),
      .mode     (mode),
      .clip_val (clip_val),
      .act_y    (act_data[k*IN_W +: IN_W]),
      .sat_x    (s1_data[k*IN_W +: IN_W]),
      .sat_y    (sat_data[k*OUT_W +: OUT_W])
    );
  end

  // Flag every output lane that currently reads zero
  always_comb begin
    zero_flags = '0;
    for (int k = 0; k < LANES; k++) begin
      zero_flags[k] = ~|out_data[k*OUT_W +: OUT_W];
    end
  end

  assign zero_inc = CNT_W'(count_set(zero_flags));

  // S1: capture activated lanes; mode and clip are consumed here so they
  // travel with the beat implicitly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld  <= 1'b0;
      s1_data <= '0;
    end else if (in_ready) begin
      s1_vld <= in_valid;
      if (in_valid) begin
        s1_data <= act_data;
      end
    end
  end

  // S2: saturate S1 into the output register whenever the output can move
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (s2_adv) begin
      out_valid <= s1_vld;
      if (s1_vld) begin
        out_data <= sat_data;
      end
    end
  end

  // Sparsity counter; clear wins over a same-cycle output handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_cnt <= '0;
    end else if (cnt_clr) begin
      zero_cnt <= '0;
    end else if (out_fire) begin
      zero_cnt <= zero_cnt + zero_inc;
    end
  end

endmodule
